// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, prefetches into a small FWFT FIFO, hands words to decode.
// Optional build macro FETCH_BOUND_CHECK_EN: out-of-range fetches push one NOP fault entry, then halt.
module instr_fetch_ctrl #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    MEM_SIZE   = 512,
  parameter int                    FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                              clk,
  input  logic                              reset,
  output logic [ADDR_WIDTH-1:0]             imem_addr,
  input  logic [DATA_WIDTH-1:0]             imem_instr,
  input  logic                              redirect_valid,
  input  logic [ADDR_WIDTH-1:0]             redirect_pc,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_WIDTH-1:0]             out_instr,
  output logic [ADDR_WIDTH-1:0]             out_pc,
  output logic                              out_fault,
  output logic                              misalign_err,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [DATA_WIDTH-1:0] NOP_INSTR = DATA_WIDTH'(32'h0000_0013);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || MEM_SIZE < 1) begin : g_bad_params
    $error("instr_fetch_ctrl: FIFO_DEPTH must be a power of two >= 2 and MEM_SIZE >= 1");
  end

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      count;
  logic                  halted;
  logic                  fault_entry;
  logic                  push;
  logic                  pop;

  logic [ADDR_WIDTH-1:0] pc_mem    [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] instr_mem [FIFO_DEPTH];

  assign imem_addr  = fetch_pc;
  assign fifo_count = count;
  assign out_valid  = (count != '0);
  assign pop        = out_valid & out_ready;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign push       = !redirect_valid && !halted && ((count < CNT_W'(FIFO_DEPTH)) || pop);

  assign out_pc    = out_valid ? pc_mem[rd_ptr]    : '0;
  assign out_instr = out_valid ? instr_mem[rd_ptr] : '0;

`ifdef FETCH_BOUND_CHECK_EN
  logic fault_mem [FIFO_DEPTH];
  logic halted_q;

  assign halted      = halted_q;
  assign fault_entry = (fetch_pc >> 2) >= ADDR_WIDTH'(MEM_SIZE);
  assign out_fault   = out_valid & fault_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      halted_q <= 1'b0;
    end else if (redirect_valid) begin
      halted_q <= 1'b0;
    end else if (push && fault_entry) begin
      halted_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fault_mem[wr_ptr] <= fault_entry;
    end
  end
`else
  assign halted      = 1'b0;
  assign fault_entry = 1'b0;
  assign out_fault   = 1'b0;
`endif

  // NOTE: FIFO storage has no reset; every read is qualified by out_valid, so stale slots are never seen.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= fetch_pc;
      instr_mem[wr_ptr] <= fault_entry ? NOP_INSTR : imem_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc     <= RESET_PC;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      misalign_err <= 1'b0;
    end else if (redirect_valid) begin
      // Redirect wins over any handshake this cycle: flush and restart at the aligned target.
      fetch_pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      if (redirect_pc[1:0] != 2'b00) begin
        misalign_err <= 1'b1;
      end
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        if (!fault_entry) begin
          fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl with a scoreboard queue of expected fetch entries.
// Memory model: word i holds 0x1000_0000 + i.
module tb_instr_fetch_ctrl;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_fault;
  logic        misalign_err;
  logic [2:0]  fifo_count;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  instr_fetch_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .out_fault     (out_fault),
    .misalign_err  (misalign_err),
    .fifo_count    (fifo_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return 32'h1000_0000 + (addr >> 2);
  endfunction

  assign imem_instr = mem_word(imem_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_expected(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] pc;
      pc = start + 32'(4 * i);
      exp_q.push_back('{pc: pc, instr: mem_word(pc), fault: 1'b0});
    end
  endtask

  // Sample between edges; a handshake seen here is consumed at the next rising edge.
  task automatic cycle();
    exp_t e;
    #1;
    if (!reset && !redirect_valid && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_pop", {31'd0, out_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_pc", out_pc, e.pc);
        check("sb_instr", out_instr, e.instr);
        check("sb_fault", {31'd0, out_fault}, {31'd0, e.fault});
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n, input bit expect_valid);
    for (int i = 0; i < n; i++) begin
      if (expect_valid) check("stream_valid", {31'd0, out_valid}, 32'd1);
      cycle();
    end
  endtask

  task automatic redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    cycle();
    redirect_valid = 1'b0;
    exp_q.delete();
    load_expected({target[31:2], 2'b00}, 100);
    check("redir_count", {29'd0, fifo_count}, 32'd0);
    check("redir_valid", {31'd0, out_valid}, 32'd0);
    cycle();
    check("redir_first_valid", {31'd0, out_valid}, 32'd1);
    check("redir_first_pc", out_pc, {target[31:2], 2'b00});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int guard;
    reset          = 1'b1;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    cycle();
    cycle();

    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_count", {29'd0, fifo_count}, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_misalign", {31'd0, misalign_err}, 32'd0);
    check("rst_fault", {31'd0, out_fault}, 32'd0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_instr", out_instr, 32'h0);

    // Streaming from reset: first word visible one cycle after release, then one per cycle.
    reset = 1'b0;
    load_expected(32'h0, 100);
    cycle();
    check("first_pc", out_pc, 32'h0);
    check("first_instr", out_instr, 32'h1000_0000);
    run(12, 1'b1);

    // Stall: FIFO fills, head and fetch address hold.
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("stall_head_pc", out_pc, exp_q[0].pc);
      cycle();
    end
    check("stall_count", {29'd0, fifo_count}, 32'd4);
    check("stall_addr", imem_addr, exp_q[0].pc + 32'd16);
    out_ready = 1'b1;
    cycle();
    check("full_pop_push_count", {29'd0, fifo_count}, 32'd4);
    run(8, 1'b1);

    // Redirect while full with ready high.
    out_ready = 1'b0;
    run(6, 1'b0);
    check("prefill_count", {29'd0, fifo_count}, 32'd4);
    out_ready = 1'b1;
    redirect(32'h40);
    check("redir_instr", out_instr, 32'h1000_0010);
    check("no_misalign", {31'd0, misalign_err}, 32'd0);
    run(5, 1'b1);

    // Misaligned redirect: sticky error, target aligned down.
    redirect(32'h42);
    check("misalign_set", {31'd0, misalign_err}, 32'd1);
    run(5, 1'b1);
    check("misalign_sticky", {31'd0, misalign_err}, 32'd1);

    // PC wraps modulo 2^32.
    redirect(32'hFFFF_FFF8);
    run(6, 1'b1);

    // Random backpressure, scoreboard keeps order.
    for (int i = 0; i < 30; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    out_ready = 1'b1;

    // Reset mid-stream once fetch reaches 0x20.
    redirect(32'h0);
    guard = 0;
    while (imem_addr !== 32'h20 && guard < 20) begin
      cycle();
      guard++;
    end
    check("reach_pc20", imem_addr, 32'h20);
    reset = 1'b1;
    cycle();
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_count", {29'd0, fifo_count}, 32'd0);
    check("mid_rst_misalign", {31'd0, misalign_err}, 32'd0);
    reset = 1'b0;
    exp_q.delete();
    load_expected(32'h0, 100);
    check("mid_rst_addr", imem_addr, 32'h0);
    cycle();
    check("restart_pc", out_pc, 32'h0);
    run(6, 1'b1);

`ifdef FETCH_BOUND_CHECK_EN
    // Bound check: last legal word, then one fault NOP, then halt until redirect.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h7FC;
    cycle();
    redirect_valid = 1'b0;
    exp_q.delete();
    exp_q.push_back('{pc: 32'h7FC, instr: mem_word(32'h7FC), fault: 1'b0});
    exp_q.push_back('{pc: 32'h800, instr: 32'h0000_0013, fault: 1'b1});
    run(6, 1'b0);
    check("bound_drained", exp_q.size(), 32'd0);
    check("bound_halt_valid", {31'd0, out_valid}, 32'd0);
    check("bound_halt_count", {29'd0, fifo_count}, 32'd0);
    redirect(32'h0);
    run(4, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
